// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the MIPS-subset CPU front end:
//                fetch FSM state encoding, opcode field values, reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // Opcode field (instr[31:26]) values seen by the control unit
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Word-aligned boot address
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_calc
//  Description : Combinational next-PC selection. Computes sequential, branch
//                and jump targets from the current pc and instruction word and
//                picks one by priority Jump > (Branch & zero) > pc+4.
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // The opcode bits do not influence the target arithmetic.
  logic unused_opcode_bits;
  assign unused_opcode_bits = &{1'b0, instr[31:26]};

  // All additions wrap modulo 2^32 by truncation to 32 bits.
  assign pc4           = pc + 32'd4;
  assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pc4 + branch_off;
  assign jump_target   = {pc4[31:28], instr[25:0], 2'b00};

  // Priority select: a jump overrides any simultaneous branch request.
  always_comb begin
    next_pc = pc4;
    if (Jump) begin
      next_pc = jump_target;
    end else if (Branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Multi-cycle instruction fetch and PC sequencer. Fetches a word
//                over a req/ack handshake, presents it for one EXEC cycle, then
//                commits the next PC from the control unit's PCWre/Jump/Branch
//                and the ALU zero flag. PCWre=0 latches the unit in HALT.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ack,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic             instr_valid,
  input  logic             PCWre,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             zero,
  output logic [31:0]      pc,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [31:0]      next_pc;

  next_pc_calc u_next_pc_calc (
    .pc      (pc_q),
    .instr   (instr_q),
    .Jump    (Jump),
    .Branch  (Branch),
    .zero    (zero),
    .next_pc (next_pc)
  );

  // State, PC, instruction and counter registers with async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic: ack only matters in FETCH, control inputs only in EXEC.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!PCWre) begin
          state_d = HALT;
        end else begin
          pc_d      = next_pc;
          retired_d = retired_q + C_CNT_ONE;
          state_d   = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Moore outputs decoded from registered state only.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == EXEC);
  assign halted      = (state_q == HALT);
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign pc          = pc_q;
  assign retired     = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit with a behavioural
//                PC/retire model and randomized memory wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic        PCWre;
  logic        Jump;
  logic        Branch;
  logic        zero;
  logic [31:0] pc;
  logic        halted;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_retired;
  logic        m_halted;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .instr       (instr),
    .op          (op),
    .instr_valid (instr_valid),
    .PCWre       (PCWre),
    .Jump        (Jump),
    .Branch      (Branch),
    .zero        (zero),
    .pc          (pc),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural next-PC rule written with plain integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                           input logic j, input logic b, input logic z);
    longint seq;
    longint off;
    seq = (longint'(cur) + 4) % 64'h1_0000_0000;
    if (j)
      return 32'((seq / 64'h1000_0000) * 64'h1000_0000 + longint'(w[25:0]) * 4);
    if (b && z) begin
      off = longint'($signed(w[15:0])) * 4;
      return 32'((seq + off + 64'h1_0000_0000) % 64'h1_0000_0000);
    end
    return 32'(seq);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    imem_ack = 1'b0;
    rst_n    = 1'b0;
    #3;
    @(negedge clk);
    rst_n     = 1'b1;
    m_pc      = 32'h0;
    m_instr   = 32'h0;
    m_retired = 32'h0;
    m_halted  = 1'b0;
  endtask

  // One full instruction: FETCH with 'waits' stalled cycles, then EXEC.
  // Entered and left at a falling edge with the DUT expected in FETCH.
  task automatic do_instr(input logic [31:0] w, input int waits,
                          input logic pcwre, input logic j, input logic b, input logic z);
    for (int k = 0; k <= waits; k++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_outputs: req=%b addr=%h valid=%b halted=%b, want req=1 addr=%h valid=0 halted=0",
                 imem_req, imem_addr, instr_valid, halted, m_pc);
      end
      n_checks++;
      if (instr !== m_instr) begin
        n_fail++;
        $display("FAIL instr_hold: got %h want %h", instr, m_instr);
      end
      imem_ack   = (k == waits);
      imem_rdata = (k == waits) ? w : $urandom;
      PCWre      = 1'($urandom);
      Jump       = 1'($urandom);
      Branch     = 1'($urandom);
      zero       = 1'($urandom);
      @(negedge clk);
    end
    m_instr = w;
    n_checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== w || op !== w[31:26] ||
        pc !== m_pc || retired !== m_retired) begin
      n_fail++;
      $display("FAIL exec_outputs: valid=%b req=%b instr=%h op=%h pc=%h ret=%0d, want valid=1 req=0 instr=%h op=%h pc=%h ret=%0d",
               instr_valid, imem_req, instr, op, pc, retired, w, w[31:26], m_pc, m_retired);
    end
    imem_ack   = 1'($urandom);
    imem_rdata = $urandom;
    PCWre      = pcwre;
    Jump       = j;
    Branch     = b;
    zero       = z;
    @(negedge clk);
    imem_ack = 1'b0;
    if (pcwre) begin
      m_pc      = ref_next(m_pc, w, j, b, z);
      m_retired = m_retired + 1;
    end else begin
      m_halted = 1'b1;
    end
    n_checks++;
    if (pc !== m_pc || retired !== m_retired || halted !== m_halted || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL commit: pc=%h ret=%0d halted=%b valid=%b, want pc=%h ret=%0d halted=%b valid=0",
               pc, retired, halted, instr_valid, m_pc, m_retired, m_halted);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    #1;
    n_checks++;
    if (pc !== 32'h0 || instr !== 32'h0 || op !== 6'h0 || instr_valid !== 1'b0 ||
        halted !== 1'b0 || retired !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: pc=%h instr=%h op=%h valid=%b halted=%b ret=%0d, want all zero",
               pc, instr, op, instr_valid, halted, retired);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    m_pc      = 32'h0;
    m_instr   = 32'h0;
    m_retired = 32'h0;
    m_halted  = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release_req: req=%b addr=%h, want req=1 addr=00000000", imem_req, imem_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 3; i++)
      do_instr({6'b000000, 26'($urandom)}, 0, 1'b1, 1'b0, 1'b0, 1'($urandom));
    n_checks++;
    if (pc !== 32'h0000_000C || retired !== 32'd3) begin
      n_fail++;
      $display("FAIL zero_wait_seq: pc=%h ret=%0d, want pc=0000000c ret=3", pc, retired);
    end
  endtask

  task automatic test_wait_states();
    do_instr({6'b001000, 26'($urandom)}, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (pc !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL wait_state_pc: got %h want 00000010", pc);
    end
  endtask

  task automatic test_branch();
    do_instr(32'h1000_FFFE, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (pc !== 32'h0000_000C) begin
      n_fail++;
      $display("FAIL branch_taken: got %h want 0000000c", pc);
    end
    do_instr(32'h0000_0020, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr(32'h1000_FFFE, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (pc !== 32'h0000_0014) begin
      n_fail++;
      $display("FAIL branch_not_taken: got %h want 00000014", pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] w;
      w = $urandom;
      do_instr(w, int'($urandom_range(0, 3)), 1'b1,
               ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
    end
  endtask

  // Walk every 256 MB region via jump-to-last-word plus a sequential step.
  task automatic test_jump_wrap();
    for (int r = 0; r < 16; r++) begin
      do_instr({6'b000010, 26'h3FF_FFFF}, 0, 1'b1, 1'b1, 1'($urandom), 1'($urandom));
      do_instr({6'b000000, 26'($urandom)}, int'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'($urandom));
      if (r == 2) begin
        n_checks++;
        if (pc !== 32'h3000_0000) begin
          n_fail++;
          $display("FAIL region_step: got %h want 30000000", pc);
        end
        do_instr(32'h0800_0040, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (pc !== 32'h3000_0100) begin
          n_fail++;
          $display("FAIL jump_over_branch: got %h want 30000100", pc);
        end
      end
    end
    n_checks++;
    if (pc !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h want 00000000", pc);
    end
  endtask

  task automatic test_halt();
    do_instr({6'b111111, 26'($urandom)}, 1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 10; i++) begin
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      PCWre      = 1'($urandom);
      Jump       = 1'($urandom);
      Branch     = 1'($urandom);
      zero       = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== m_pc ||
          retired !== m_retired || instr !== m_instr) begin
        n_fail++;
        $display("FAIL halt_frozen: halted=%b req=%b valid=%b pc=%h ret=%0d instr=%h, want 1 0 0 %h %0d %h",
                 halted, imem_req, instr_valid, pc, retired, instr, m_pc, m_retired, m_instr);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset();
    do_instr({6'b000010, 26'h10}, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (pc !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL reach_0x40: got %h want 00000040", pc);
    end
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pc !== 32'h0 || imem_addr !== 32'h0 || instr !== 32'h0 || op !== 6'h0 ||
        retired !== 32'h0 || halted !== 1'b0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h addr=%h instr=%h ret=%0d halted=%b valid=%b req=%b, want reset values",
               pc, imem_addr, instr, retired, halted, instr_valid, imem_req);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    m_pc      = 32'h0;
    m_instr   = 32'h0;
    m_retired = 32'h0;
    m_halted  = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset_req: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
    @(negedge clk);
    do_instr($urandom, 0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    PCWre      = 1'b1;
    Jump       = 1'b0;
    Branch     = 1'b0;
    zero       = 1'b0;
    m_pc       = 32'h0;
    m_instr    = 32'h0;
    m_retired  = 32'h0;
    m_halted   = 1'b0;

    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_random();
    test_jump_wrap();
    test_halt();
    test_reset_mid_fetch();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
